// File: rtl/game_pkg.sv
// Shared types and constants for the colour-matching game.
package game_pkg;

  typedef logic [2:0] colour_t;

  localparam int      NUM_COLOURS    = 5;
  localparam colour_t INVALID_COLOUR = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    JUDGE,
    LOCKOUT,
    WAIT_RELEASE
  } judge_state_t;

endpackage

// File: rtl/answer_judge_if.sv
// Player-side signal bundle of the answer judge.
// The master drives the button, switches, answer and game_over and receives
// the judgement. The slave is the judge itself.
interface answer_judge_if;
  import game_pkg::*;

  logic                   game_over;
  logic                   submit_n;
  logic [NUM_COLOURS-1:0] sw;
  colour_t                answer_colour;
  logic                   correct_pulse;
  logic                   wrong_pulse;
  logic                   busy;
  colour_t                last_guess;

  modport master (
    output game_over, submit_n, sw, answer_colour,
    input  correct_pulse, wrong_pulse, busy, last_guess
  );

  modport slave (
    input  game_over, submit_n, sw, answer_colour,
    output correct_pulse, wrong_pulse, busy, last_guess
  );

endinterface

// File: rtl/debouncer.sv
// Two-flop synchroniser plus stability counter for an active-low pushbutton.
// The debounced level starts released (high) and follows the synchronised
// input only after it has disagreed for DEBOUNCE_CYCLES consecutive cycles.
// fall is a one-cycle pulse on the cycle the debounced level becomes low.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  localparam int              CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;

  // Bring the raw button into the clock domain; resets to the released level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Count consecutive disagreeing cycles; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (sync_b == level) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        level <= sync_b;
        fall  <= level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/answer_judge.sv
// Answer judge: debounces the submit button, captures the switch guess on
// each press, compares it with the current answer colour and emits one
// correct/wrong pulse per press, followed by a lockout and a wait for release.
// Optional build macro: ANSWER_JUDGE_STRICT_ONEHOT_EN -- when defined, two or
// more switches set is an invalid guess; otherwise the lowest set bit wins.
module answer_judge
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LOCKOUT_CYCLES  = 25_000_000
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  answer_judge_if.slave  bus
);

  localparam int              LCK_W     = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCKOUT_CYCLES - 1);

  logic                   btn_level;
  logic                   btn_fall;
  logic [NUM_COLOURS-1:0] sw_meta;
  logic [NUM_COLOURS-1:0] sw_sync;
  colour_t                guess_now;
  logic                   guess_match;

  judge_state_t           state;
  logic [LCK_W-1:0]       lock_cnt;
  colour_t                guess_q;
  logic                   match_q;
  logic                   busy_q;
  colour_t                last_guess_q;

  // Map the switch pattern to a colour code or INVALID_COLOUR.
  function automatic colour_t decode_guess(input logic [NUM_COLOURS-1:0] s);
    colour_t g;
    g = INVALID_COLOUR;
`ifdef ANSWER_JUDGE_STRICT_ONEHOT_EN
    if ($countones(s) == 1) begin
      for (int i = 0; i < NUM_COLOURS; i++) begin
        if (s[i]) g = colour_t'(i);
      end
    end
`else
    for (int i = NUM_COLOURS - 1; i >= 0; i--) begin
      if (s[i]) g = colour_t'(i);
    end
`endif
    return g;
  endfunction

  debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_submit (
    .clk   (CLOCK_50),
    .rst   (reset),
    .raw   (bus.submit_n),
    .level (btn_level),
    .fall  (btn_fall)
  );

  // Switches only need synchronising: they are sampled once, at press time.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= bus.sw;
      sw_sync <= sw_meta;
    end
  end

  assign guess_now   = decode_guess(sw_sync);
  assign guess_match = (guess_now != INVALID_COLOUR) && (guess_now == bus.answer_colour);

  // Judgement FSM: capture on press, judge for one cycle, lock out, await release.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lock_cnt     <= '0;
      guess_q      <= '0;
      match_q      <= 1'b0;
      busy_q       <= 1'b0;
      last_guess_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          lock_cnt <= '0;
          // A press during game over is dropped; the button must be released
          // and pressed again to produce a new falling edge.
          if (btn_fall && !bus.game_over) begin
            guess_q <= guess_now;
            match_q <= guess_match;
            busy_q  <= 1'b1;
            state   <= JUDGE;
          end
        end
        JUDGE: begin
          last_guess_q <= guess_q;
          lock_cnt     <= '0;
          state        <= LOCKOUT;
        end
        LOCKOUT: begin
          if (lock_cnt >= LOCK_LAST) begin
            lock_cnt <= '0;
            state    <= WAIT_RELEASE;
          end else begin
            lock_cnt <= lock_cnt + LCK_W'(1);
          end
        end
        WAIT_RELEASE: begin
          if (btn_level) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // The verdict is fixed at capture time; game_over only gates its visibility
  // so that a game ending on the judge cycle suppresses the pulse.
  assign bus.correct_pulse = (state == JUDGE) && !bus.game_over && match_q;
  assign bus.wrong_pulse   = (state == JUDGE) && !bus.game_over && !match_q;
  assign bus.busy          = busy_q;
  assign bus.last_guess    = last_guess_q;

endmodule

// File: tb/tb_answer_judge.sv
// Scoreboard bench for answer_judge with short debounce/lockout periods.
module tb_answer_judge;
  import game_pkg::*;

  localparam int DEB  = 4;
  localparam int LOCK = 8;
  localparam int LAT  = 2 + DEB + 1;

  typedef struct {
    logic    corr;
    colour_t lg;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   pulse_cnt;
  int   pulse_cyc;
  int   fall_cyc;
  exp_t exp_q[$];
  logic    pending_lg;
  colour_t lg_exp;

  answer_judge_if bus ();

  answer_judge #(
    .DEBOUNCE_CYCLES (DEB),
    .LOCKOUT_CYCLES  (LOCK)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected judgement from the game rules, independent of any RTL structure.
  function automatic void rules(input logic [4:0] s, input colour_t a,
                                output logic corr, output colour_t g);
    int  n;
    bit  valid;
    n = $countones(s);
`ifdef ANSWER_JUDGE_STRICT_ONEHOT_EN
    valid = (n == 1);
`else
    valid = (n >= 1);
`endif
    g = 3'd7;
    if (valid) begin
      for (int i = 4; i >= 0; i--) if (s[i]) g = colour_t'(i);
    end
    corr = valid && (g == a);
  endfunction

  task automatic check(input string name, input int actual, input int required);
    vectors++;
    if (actual !== required) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Monitor: pops one expectation per presented pulse, then checks last_guess.
  always @(negedge clk) begin
    exp_t e;
    if (bus.correct_pulse || bus.wrong_pulse) begin
      check("pulse_exclusive", int'(bus.correct_pulse && bus.wrong_pulse), 0);
      pulse_cnt++;
      pulse_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_correct", int'(bus.correct_pulse), int'(e.corr));
        pending_lg = 1'b1;
        lg_exp     = e.lg;
      end
    end else if (pending_lg) begin
      pending_lg = 1'b0;
      check("last_guess", int'(bus.last_guess), int'(lg_exp));
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", int'(bus.busy === 1'b0), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Clean press held for LAT+2+extra cycles, answer scrambled on the judge cycle.
  task automatic press(input logic [4:0] s, input colour_t a, input int extra);
    logic    c;
    colour_t g;
    int      pc0;
    bus.sw            = s;
    bus.answer_colour = a;
    rules(s, a, c, g);
    repeat (3) @(posedge clk);
    #1;
    bus.submit_n = 1'b0;
    fall_cyc     = cyc;
    pc0          = pulse_cnt;
    exp_q.push_back('{corr: c, lg: g});
    repeat (LAT) @(posedge clk);
    #1;
    bus.answer_colour = colour_t'($urandom_range(0, 4));
    repeat (2 + extra) @(posedge clk);
    #1;
    check("one_pulse_per_press", pulse_cnt - pc0, 1);
    check("press_to_pulse_latency", pulse_cyc - fall_cyc, LAT);
    check("busy_while_held", int'(bus.busy), 1);
    bus.submit_n = 1'b1;
    wait_idle(200);
  endtask

  initial begin
    logic [4:0] s;
    int         pc0;
    cyc = 0; vectors = 0; miscompares = 0; pulse_cnt = 0; pulse_cyc = 0;
    pending_lg = 1'b0; lg_exp = '0;
    rst = 1'b1;
    bus.submit_n = 1'b1; bus.sw = '0; bus.answer_colour = '0; bus.game_over = 1'b0;
    #1;
    check("reset_correct", int'(bus.correct_pulse), 0);
    check("reset_wrong", int'(bus.wrong_pulse), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_last_guess", int'(bus.last_guess), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Correct and wrong guesses.
    press(5'b00100, 3'd2, 0);
    press(5'b00001, 3'd3, 5);

    // Multi-bit and zero switches.
    press(5'b00110, 3'd1, 0);
    press(5'b00000, 3'd0, 0);

    // Bounce then a long hold gives one judgement; a re-press gives another.
    bus.sw = 5'b01000; bus.answer_colour = 3'd3;
    repeat (3) @(posedge clk);
    #1;
    pc0 = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      bus.submit_n = ~bus.submit_n;
      repeat (2) @(posedge clk);
      #1;
    end
    check("no_pulse_while_bouncing", pulse_cnt - pc0, 0);
    bus.submit_n = 1'b0;
    exp_q.push_back('{corr: 1'b1, lg: 3'd3});
    repeat (50) @(posedge clk);
    #1;
    check("bounce_single_judgement", pulse_cnt - pc0, 1);
    bus.submit_n = 1'b1;
    wait_idle(200);
    press(5'b01000, 3'd1, 0);

    // Press during game over: no pulse, busy stays low.
    bus.game_over = 1'b1;
    pc0 = pulse_cnt;
    @(posedge clk); #1;
    bus.submit_n = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check("busy_low_in_game_over", int'(bus.busy), 0);
    end
    bus.submit_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.game_over = 1'b0;
    check("no_pulse_in_game_over", pulse_cnt - pc0, 0);

    // game_over rising on the judge cycle suppresses the pulse.
    bus.sw = 5'b00010; bus.answer_colour = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    pc0 = pulse_cnt;
    bus.submit_n = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    bus.game_over = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("busy_after_suppressed_judge", int'(bus.busy), 1);
    check("suppressed_pulse", pulse_cnt - pc0, 0);
    bus.game_over = 1'b0;
    bus.submit_n  = 1'b1;
    wait_idle(200);

    // Reset on the third lockout cycle with the button held.
    bus.sw = 5'b00100; bus.answer_colour = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    bus.submit_n = 1'b0;
    exp_q.push_back('{corr: 1'b1, lg: 3'd2});
    repeat (LAT + 3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midlock_reset_busy", int'(bus.busy), 0);
    check("midlock_reset_correct", int'(bus.correct_pulse), 0);
    check("midlock_reset_wrong", int'(bus.wrong_pulse), 0);
    check("midlock_reset_last_guess", int'(bus.last_guess), 0);
    check("midlock_reset_state_idle", int'(dut.state == IDLE), 1);
    @(posedge clk); #1;
    rst      = 1'b0;
    fall_cyc = cyc;
    pc0      = pulse_cnt;
    exp_q.push_back('{corr: 1'b1, lg: 3'd2});
    repeat (LAT + 2) @(posedge clk);
    #1;
    check("rejudge_after_reset", pulse_cnt - pc0, 1);
    check("rejudge_latency", pulse_cyc - fall_cyc, LAT);
    bus.submit_n = 1'b1;
    wait_idle(200);

    // Randomized presses.
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 1) == 1) s = 5'(1) << $urandom_range(0, 4);
      else s = 5'($urandom_range(0, 31));
      press(s, colour_t'($urandom_range(0, 4)), int'($urandom_range(0, 20)));
    end

    repeat (5) @(posedge clk);
    #1;
    check("all_expected_pulses_seen", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/answer_judge.md
# answer_judge

Player-answer front end for the colour-matching game. Synchronises and debounces the submit pushbutton and the colour-select switches, captures the player's guess on each debounced press, and compares it against the current answer colour from the colour generator. Emits a single-cycle correct or wrong pulse to the scorer and colour generator, then enforces a lockout so one press yields exactly one judgement.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles before the debounced button level changes (20 ms at 50 MHz).
- `LOCKOUT_CYCLES`, 25_000_000: post-judgement cycles during which presses are ignored (0.5 s).
- `CLOCK_50` input 1: sole clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `game_over` input 1: level from the timer; high blocks all judgements.
- `submit_n` input 1: raw pushbutton, active-low, asynchronous to `CLOCK_50`.
- `sw` input 5: raw colour-select switches; bit i selects colour code i.
- `answer_colour` input 3: current target colour code, synchronous to `CLOCK_50`.
- `correct_pulse` output 1: one-cycle pulse on a matching guess.
- `wrong_pulse` output 1: one-cycle pulse on a mismatching or invalid guess.
- `busy` output 1: high in JUDGE, LOCKOUT and WAIT_RELEASE.
- `last_guess` output 3: colour code of the most recent judged guess, or 3'b111 if it was invalid.

## Operation
- `submit_n` and `sw` each pass through a 2-flop synchroniser.
- Debouncer:
  - The debounced level starts high (released).
  - It takes the synchronised value once that value has differed from the current debounced level for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any bounce restarts the count.
- Press event: falling edge of the debounced level.
- Guess decode (the `ANSWER_JUDGE_STRICT_ONEHOT_EN` macro alters this, see Configuration):
  - Exactly one bit set: the guess is that bit's index.
  - Zero bits set: the guess is invalid.
- FSM states:
  - IDLE
    - On a press event with `game_over` low: latch the decoded guess and `answer_colour`, then go to JUDGE.
    - A press while `game_over` is high is discarded and the FSM stays in IDLE.
  - JUDGE (one cycle)
    - Valid guess equal to the latched answer: assert `correct_pulse`.
    - Otherwise: assert `wrong_pulse`.
    - Update `last_guess`, then go to LOCKOUT.
  - LOCKOUT
    - Counts `LOCKOUT_CYCLES` cycles, then goes to WAIT_RELEASE.
  - WAIT_RELEASE
    - Goes to IDLE once the debounced level is high.
    - A button held through lockout never produces a second judgement.
- `game_over` rising while in JUDGE: the pulse is suppressed and the FSM goes to LOCKOUT.
- `game_over` rising in any other state: no pulse is emitted.
- `correct_pulse` and `wrong_pulse` are never high together.

## Timing
- Reset values:
  - Outputs: `correct_pulse`, `wrong_pulse` and `busy` 0; `last_guess` 3'b000.
  - FSM: IDLE.
  - Internal: counters 0; debounced level 1; synchroniser flops 1 for `submit_n`, 0 for `sw`.
- Latency:
  - A raw `submit_n` fall that stays stable produces the press event 2 + `DEBOUNCE_CYCLES` cycles later.
  - The pulse follows the press event by 1 cycle (the JUDGE cycle).
- Sampling: guess and answer are sampled on the press-event cycle. An `answer_colour` change on the pulse cycle does not affect the current judgement.
- `busy` rises the cycle after the press event and falls on the cycle IDLE is re-entered.
- Lockout counter width is `$clog2(LOCKOUT_CYCLES+1)` bits; debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)` bits. Neither counter wraps: each saturates and is cleared on exit.
- Reset asserted mid-lockout: the block returns to IDLE immediately, and a held button must still debounce from the released state.

## Configuration
- `ANSWER_JUDGE_STRICT_ONEHOT_EN` defined:
  - Two or more `sw` bits set is an invalid guess, reported as `wrong_pulse` with `last_guess` = 3'b111.
- Undefined:
  - The lowest-index set bit wins.
  - Zero bits set still counts as invalid.

## Structure
- Shared package `game_pkg`:
  - `colour_t` (logic [2:0]).
  - `NUM_COLOURS` = 5.
  - `INVALID_COLOUR` = 3'b111.
  - `judge_state_t` enum {IDLE, JUDGE, LOCKOUT, WAIT_RELEASE}.
- One sub-module, `debouncer`: synchroniser, stability counter and debounced-level output, parameterised on `DEBOUNCE_CYCLES`. It is instantiated once for `submit_n`. The switches use only the synchroniser, since they are sampled at press time.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LOCKOUT_CYCLES`=8.
- Correct guess: `sw`=5'b00100, `answer_colour`=2, clean press → `correct_pulse` for exactly 1 cycle, 2+4+1 cycles after the fall; `last_guess`=2; `busy` high until release.
- Wrong guess: `sw`=5'b00001, `answer_colour`=3 → one `wrong_pulse`, `last_guess`=0.
- Bounce: toggle `submit_n` every 2 cycles for 20 cycles, then hold low → exactly one judgement. Holding for 50 cycles → still one judgement; a release and re-press after lockout → a second judgement.
- Game over: `game_over`=1 with a press → no pulses and `busy` stays 0. `game_over` rising on the JUDGE cycle → pulse suppressed.
- Multi-bit and zero switches: `sw`=5'b00110, `answer_colour`=1:
  - Macro defined: `wrong_pulse`, `last_guess`=7.
  - Macro undefined: `correct_pulse`, `last_guess`=1.
  - `sw`=0 in either build: `wrong_pulse`.
- Reset mid-lockout: assert `reset` in cycle 3 of LOCKOUT → all outputs 0 on the same edge, FSM in IDLE. Button held through reset → judged again only after full debounce.
